// File: rtl/uart_rx_deser.sv
// UART receive deserializer: start detect, 3-sample majority per bit,
// optional parity check, stop check, registered one-cycle result pulses.
module uart_rx_deser #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [5:0]            Prescale,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                state_q, state_d;
   logic [5:0]            edge_cnt_q, edge_cnt_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [5:0]            presc_q, presc_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic [2:0]            smp_q, smp_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_fail_q, par_fail_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  data_valid_q, data_valid_d;
   logic                  par_err_q, par_err_d;
   logic                  stp_err_q, stp_err_d;

   logic [5:0]            half;
   logic                  win_end;
   logic                  maj;
   logic                  exp_par;

   assign half    = presc_q >> 1;
   assign win_end = (edge_cnt_q == presc_q - 6'd1);
   assign maj     = (smp_q[0] & smp_q[1]) |
                    (smp_q[0] & smp_q[2]) |
                    (smp_q[1] & smp_q[2]);
   assign exp_par = (^shift_q) ^ par_typ_q;

   // Next-state: bit timing, centre sampling and frame sequencing
   always_comb begin
      state_d      = state_q;
      edge_cnt_d   = edge_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      presc_d      = presc_q;
      par_en_d     = par_en_q;
      par_typ_d    = par_typ_q;
      smp_d        = smp_q;
      shift_d      = shift_q;
      par_fail_d   = par_fail_q;
      p_data_d     = p_data_q;
      data_valid_d = 1'b0;
      par_err_d    = 1'b0;
      stp_err_d    = 1'b0;

      if (state_q != IDLE) begin
         edge_cnt_d = win_end ? 6'd0 : edge_cnt_q + 6'd1;
         if (edge_cnt_q == half - 6'd1) smp_d[0] = RX_IN;
         if (edge_cnt_q == half)        smp_d[1] = RX_IN;
         if (edge_cnt_q == half + 6'd1) smp_d[2] = RX_IN;
      end

      case (state_q)
         IDLE: begin
            if (!RX_IN) begin
               state_d    = START;
               edge_cnt_d = 6'd0;
               bit_cnt_d  = '0;
               presc_d    = Prescale;
               par_en_d   = PAR_EN;
               par_typ_d  = PAR_TYP;
               par_fail_d = 1'b0;
            end
         end
         START: begin
            if (win_end) state_d = maj ? IDLE : DATA;
         end
         DATA: begin
            if (win_end) begin
               for (int i = 0; i < DATA_WIDTH; i++) begin
                  if (bit_cnt_q == CW'(i)) shift_d[i] = maj;
               end
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                  state_d = par_en_q ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (win_end) begin
               par_fail_d = (maj != exp_par);
               state_d    = STOP;
            end
         end
         STOP: begin
            if (win_end) begin
               if (maj && !par_fail_q) begin
                  p_data_d     = shift_q;
                  data_valid_d = 1'b1;
               end
               par_err_d = par_fail_q;
               stp_err_d = ~maj;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q      <= IDLE;
         edge_cnt_q   <= 6'd0;
         bit_cnt_q    <= '0;
         presc_q      <= 6'd0;
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         smp_q        <= 3'b000;
         shift_q      <= '0;
         par_fail_q   <= 1'b0;
         p_data_q     <= '0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         edge_cnt_q   <= edge_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         presc_q      <= presc_d;
         par_en_q     <= par_en_d;
         par_typ_q    <= par_typ_d;
         smp_q        <= smp_d;
         shift_q      <= shift_d;
         par_fail_q   <= par_fail_d;
         p_data_q     <= p_data_d;
         data_valid_q <= data_valid_d;
         par_err_q    <= par_err_d;
         stp_err_q    <= stp_err_d;
      end
   end

   assign P_DATA     = p_data_q;
   assign data_valid = data_valid_q;
   assign par_err    = par_err_q;
   assign stp_err    = stp_err_q;

endmodule
